// File: rtl/eth_pkg.sv
// Ethernet/ARP constants and helpers shared by the ARP receive and transmit paths.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
  localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
  localparam logic [15:0] ARP_OP_REQ    = 16'd1;
  localparam logic [15:0] ARP_OP_REPLY  = 16'd2;
  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

  localparam logic [5:0] PREAMBLE_LEN = 6'd7;
  localparam logic [5:0] ETH_HDR_LEN  = 6'd14;
  localparam logic [5:0] ARP_LEN      = 6'd28;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    ETH_HEAD,
    ARP_DATA,
    RX_END
  } arp_state_e;

  // byte i of a MAC, 0 = first on the wire
  function automatic logic [7:0] mac_byte(input logic [47:0] m,
                                          input logic [2:0] i);
    logic [47:0] s;
    s = m << {i, 3'b000};
    return s[47:40];
  endfunction

  function automatic logic [7:0] ip_byte(input logic [31:0] a,
                                         input logic [1:0] i);
    logic [31:0] s;
    s = a << {i, 3'b000};
    return s[31:24];
  endfunction

endpackage

// File: rtl/arp_rx.sv
// GMII receive ARP parser: validates Ethernet/ARP headers addressed to us
// and reports the sender MAC/IP with a one-cycle done strobe.
module arp_rx
  import eth_pkg::*;
#(
  parameter logic [47:0] fpga_mac = 48'h11_22_33_44_55_66,
  parameter logic [31:0] fpga_ip  = 32'hc0_a8_00_08
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_rx_done,
  output logic        arp_rx_type,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);

  localparam logic [5:0] ETH_LAST = ETH_HDR_LEN - 6'd1;
  localparam logic [5:0] ARP_LAST = ETH_HDR_LEN + ARP_LEN - 6'd1;

  arp_state_e  state, state_next;
  logic [5:0]  cnt;
  logic        err;
  logic        bcast_ok, mac_ok;
  logic        bcast_n, mac_n;
  logic        op_req;
  logic        dv_q;
  logic [47:0] smac;
  logic [31:0] sip;
  logic        bad;
  logic        commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // dv_q resets high so a frame already in flight at reset release is skipped
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:
        if (gmii_rx_dv && !dv_q && gmii_rxd == PREAMBLE_BYTE)
          state_next = PREAMBLE;
      PREAMBLE:
        if (!gmii_rx_dv)
          state_next = IDLE;
        else if (gmii_rxd == PREAMBLE_BYTE && cnt < PREAMBLE_LEN)
          state_next = PREAMBLE;
        else if (gmii_rxd == SFD_BYTE && cnt == PREAMBLE_LEN)
          state_next = ETH_HEAD;
        else
          state_next = RX_END;
      ETH_HEAD:
        if (!gmii_rx_dv)           state_next = IDLE;
        else if (cnt == ETH_LAST)  state_next = ARP_DATA;
      ARP_DATA:
        if (!gmii_rx_dv)           state_next = IDLE;
        else if (cnt == ARP_LAST)  state_next = RX_END;
      RX_END:
        if (!gmii_rx_dv)           state_next = IDLE;
      default:
        state_next = IDLE;
    endcase
  end

  always_comb begin
    bcast_n = bcast_ok && (gmii_rxd == BCAST_MAC[47:40]);
    mac_n   = mac_ok && (gmii_rxd == mac_byte(fpga_mac, cnt[2:0]));
    bad     = 1'b0;
    case (cnt)
      6'd5:  bad = !(bcast_n || mac_n);
      6'd12: bad = gmii_rxd != ETH_TYPE_ARP[15:8];
      6'd13: bad = gmii_rxd != ETH_TYPE_ARP[7:0];
      6'd14: bad = gmii_rxd != ARP_HTYPE_ETH[15:8];
      6'd15: bad = gmii_rxd != ARP_HTYPE_ETH[7:0];
      6'd16: bad = gmii_rxd != ETH_TYPE_IP[15:8];
      6'd17: bad = gmii_rxd != ETH_TYPE_IP[7:0];
      6'd18: bad = gmii_rxd != 8'd6;
      6'd19: bad = gmii_rxd != 8'd4;
      6'd20: bad = gmii_rxd != 8'd0;
      6'd21: bad = gmii_rxd != ARP_OP_REQ[7:0] &&
                   gmii_rxd != ARP_OP_REPLY[7:0];
      6'd38, 6'd39, 6'd40, 6'd41:
        bad = gmii_rxd != ip_byte(fpga_ip, 2'(cnt - 6'd38));
      default: bad = 1'b0;
    endcase
    commit = state == ARP_DATA && gmii_rx_dv &&
             cnt == ARP_LAST && !err && !bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      err         <= 1'b0;
      bcast_ok    <= 1'b1;
      mac_ok      <= 1'b1;
      op_req      <= 1'b0;
      smac        <= '0;
      sip         <= '0;
      dv_q        <= 1'b1;
      arp_rx_done <= 1'b0;
      arp_rx_type <= 1'b0;
      src_mac     <= '0;
      src_ip      <= '0;
    end else begin
      dv_q        <= gmii_rx_dv;
      arp_rx_done <= commit;
      if (commit) begin
        src_mac     <= smac;
        src_ip      <= sip;
        arp_rx_type <= op_req;
      end
      if (state_next == IDLE) begin
        cnt      <= '0;
        err      <= 1'b0;
        bcast_ok <= 1'b1;
        mac_ok   <= 1'b1;
        op_req   <= 1'b0;
        smac     <= '0;
        sip      <= '0;
      end else begin
        case (state)
          IDLE:
            cnt <= 6'd1;
          PREAMBLE:
            cnt <= (state_next == ETH_HEAD) ? 6'd0 : cnt + 6'd1;
          ETH_HEAD, ARP_DATA: begin
            cnt <= cnt + 6'd1;
            err <= err || bad;
            if (cnt < 6'd6) begin
              bcast_ok <= bcast_n;
              mac_ok   <= mac_n;
            end
            if (cnt == 6'd21)
              op_req <= gmii_rxd == ARP_OP_REQ[7:0];
            if (cnt >= 6'd22 && cnt <= 6'd27)
              smac <= {smac[39:0], gmii_rxd};
            if (cnt >= 6'd28 && cnt <= 6'd31)
              sip <= {sip[23:0], gmii_rxd};
          end
          default: ;
        endcase
      end
    end
  end

endmodule
